ram_dp_param: RTL and testbench

- Parametrised simple-dual-port synchronous RAM; successor to the single-port RAM under verification in the same environment.
- Provides an independent write port (byte-lane enables) and read port, with configurable read latency and read-during-write mode.
- Adds a non-power-of-two depth with range checking, and per-entry "written since reset" tracking.
- Sits behind the existing RAM interface style; one instance per memory channel.

---
 rtl/ram_dp_pkg.sv | 29 ++
 rtl/ram_rd_pipe.sv | 26 ++
 rtl/ram_dp_param.sv | 118 +++++++++++
 tb/tb_ram_dp_param.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_dp_pkg.sv
// rtl/ram_dp_pkg.sv - shared types, constants and parameter checks for ram_dp_param
package ram_dp_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  localparam int MIN_RD_LAT = 1;
  localparam int MAX_RD_LAT = 4;

  // Per-read status carried alongside the data through the read pipeline
  typedef struct packed {
    logic valid;
    logic uninit;
    logic err;
    logic collision;
  } rd_resp_t;

  // True when the parameter set describes a buildable memory
  function automatic bit params_legal(int data_width, int addr_width, int depth,
                                      int rd_latency, int rdw_mode);
    return (data_width > 0) && (data_width % 8 == 0) &&
           (depth >= 1) && (depth <= (1 << addr_width)) &&
           (rd_latency >= MIN_RD_LAT) && (rd_latency <= MAX_RD_LAT) &&
           (rdw_mode == 0 || rdw_mode == 1);
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - fixed-length delay line with asynchronous clear
module ram_rd_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift one stage per clock; reset flushes every stage so nothing in flight survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[STAGES-1];

endmodule

// File: rtl/ram_dp_param.sv
// rtl/ram_dp_param.sv - simple dual-port RAM with byte enables, range checks and init tracking
module ram_dp_param
  import ram_dp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 12,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_enb,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_enb,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_uninit,
  output logic                    rd_err,
  output logic                    wr_err,
  output logic                    rd_collision
);

  localparam int                  NUM_LANES = DATA_WIDTH / 8;
  localparam int                  PIPE_W    = DATA_WIDTH + $bits(rd_resp_t);
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = DEPTH[ADDR_WIDTH:0];
  localparam rdw_mode_e           RDW       = rdw_mode_e'(RDW_MODE[0]);

  if (!params_legal(DATA_WIDTH, ADDR_WIDTH, DEPTH, RD_LATENCY, RDW_MODE)) begin : g_bad_params
    $error("ram_dp_param: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      written;

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  collision;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] s0_data;
  rd_resp_t              s0_resp;
  logic [DATA_WIDTH-1:0] out_data;
  rd_resp_t              out_resp;

  // Range decode; indices are forced to 0 when out of range so the array is never over-indexed
  assign wr_in_range = wr_enb && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;
  assign wr_idx      = wr_in_range ? wr_addr : '0;
  assign rd_idx      = rd_in_range ? rd_addr : '0;
  assign collision   = rd_enb && wr_in_range && rd_in_range && (rd_addr == wr_addr);

  // Build the word to store: disabled lanes keep old contents, or zero if never written
  always_comb begin
    wr_old  = written[wr_idx] ? mem[wr_idx] : '0;
    wr_word = wr_old;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wr_be[i]) wr_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  // Array storage is not reset; unwritten entries are masked by the written bitmap
  always_ff @(posedge clk) begin
    if (wr_in_range) mem[wr_idx] <= wr_word;
  end

  // Written bitmap and out-of-range write pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written <= '0;
      wr_err  <= 1'b0;
    end else begin
      if (wr_in_range) written[wr_idx] <= 1'b1;
      wr_err <= wr_enb && !wr_in_range;
    end
  end

  // Read lookup feeding stage 0; idle cycles carry all-zero so rd_data is 0 when not valid
  always_comb begin
    s0_data = '0;
    s0_resp = '0;
    if (rd_enb) begin
      s0_resp.valid     = 1'b1;
      s0_resp.collision = collision;
      if (!rd_in_range) begin
        s0_resp.err = 1'b1;
      end else if (collision && (RDW == RDW_WRITE_FIRST)) begin
        s0_data = wr_word;
      end else if (written[rd_idx]) begin
        s0_data = mem[rd_idx];
      end else begin
        s0_resp.uninit = 1'b1;
      end
    end
  end

  ram_rd_pipe #(
    .WIDTH  (PIPE_W),
    .STAGES (RD_LATENCY)
  ) u_rd_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  ({s0_data, s0_resp}),
    .dout ({out_data, out_resp})
  );

  assign rd_data      = out_data;
  assign rd_valid     = out_resp.valid;
  assign rd_uninit    = out_resp.uninit;
  assign rd_err       = out_resp.err;
  assign rd_collision = out_resp.collision;

endmodule

// File: tb/tb_ram_dp_param.sv
// tb/tb_ram_dp_param.sv - self-checking bench for ram_dp_param (read-first lat 2, write-first lat 4)
module tb_ram_dp_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_enb = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        rd_enb = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic [15:0] a_data, b_data;
  logic        a_valid, a_uninit, a_err, a_werr, a_coll;
  logic        b_valid, b_uninit, b_err, b_werr, b_coll;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] data;
    logic        uninit;
    logic        err;
    logic        coll;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic [15:0] d0;
    logic        u0, e0, c0;
    logic [15:0] d1;
    logic        u1, e1, c1;
    logic        werr;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vecs[$];

  ram_dp_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12), .RD_LATENCY(2), .RDW_MODE(0)) u_dut_a (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(a_data), .rd_valid(a_valid), .rd_uninit(a_uninit),
    .rd_err(a_err), .wr_err(a_werr), .rd_collision(a_coll));

  ram_dp_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12), .RD_LATENCY(4), .RDW_MODE(1)) u_dut_b (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(b_data), .rd_valid(b_valid), .rd_uninit(b_uninit),
    .rd_err(b_err), .wr_err(b_werr), .rd_collision(b_coll));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_resp(input string tag, input exp_t e, input logic [15:0] d,
                          input logic u, input logic er, input logic c);
    chk({tag, " data"}, 32'(d), 32'(e.data));
    chk({tag, " uninit"}, 32'(u), 32'(e.uninit));
    chk({tag, " err"}, 32'(er), 32'(e.err));
    chk({tag, " collision"}, 32'(c), 32'(e.coll));
    chk({tag, " latency cycle"}, 32'(cyc), 32'(e.cyc));
  endtask

  // Scoreboard monitors: pop the oldest expectation whenever a DUT presents a result
  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid) begin
        if (q_a.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL A unexpected rd_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else chk_resp("A", q_a.pop_front(), a_data, a_uninit, a_err, a_coll);
      end else chk("A idle rd_data", 32'(a_data), 32'h0);
      if (b_valid) begin
        if (q_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL B unexpected rd_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else chk_resp("B", q_b.pop_front(), b_data, b_uninit, b_err, b_coll);
      end else chk("B idle rd_data", 32'(b_data), 32'h0);
    end
  end

  function automatic vec_t mk(logic we, logic [3:0] wa, logic [15:0] wd, logic [1:0] be,
                              logic re, logic [3:0] ra,
                              logic [15:0] d0, logic u0, logic e0, logic c0,
                              logic [15:0] d1, logic u1, logic e1, logic c1, logic werr);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.re = re; v.ra = ra;
    v.d0 = d0; v.u0 = u0; v.e0 = e0; v.c0 = c0;
    v.d1 = d1; v.u1 = u1; v.e1 = e1; v.c1 = c1; v.werr = werr;
    return v;
  endfunction

  function automatic vec_t wr(logic [3:0] wa, logic [15:0] wd, logic [1:0] be, logic werr);
    return mk(1, wa, wd, be, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, werr);
  endfunction

  function automatic vec_t rd(logic [3:0] ra, logic [15:0] d, logic u, logic e);
    return mk(0, 0, 0, 0, 1, ra, d, u, e, 0, d, u, e, 0, 0);
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    wr_enb = v.we; wr_addr = v.wa; wr_data = v.wd; wr_be = v.be;
    rd_enb = v.re; rd_addr = v.ra;
    if (v.re) begin
      e.data = v.d0; e.uninit = v.u0; e.err = v.e0; e.coll = v.c0; e.cyc = cyc + 2;
      q_a.push_back(e);
      e.data = v.d1; e.uninit = v.u1; e.err = v.e1; e.coll = v.c1; e.cyc = cyc + 4;
      q_b.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    chk({tag, " pending results"}, 32'(q_a.size() + q_b.size()), 32'h0);
  endtask

  initial begin
    logic prev_werr;
    exp_t e;

    // Vector table: A is read-first (d0..c0), B is write-first (d1..c1)
    vecs.push_back(rd(5, 16'h0000, 1, 0));
    vecs.push_back(wr(3, 16'hA5C3, 2'b11, 0));
    vecs.push_back(wr(3, 16'h1200, 2'b10, 0));
    vecs.push_back(rd(3, 16'h12C3, 0, 0));
    vecs.push_back(wr(4, 16'h00FF, 2'b01, 0));
    vecs.push_back(rd(4, 16'h00FF, 0, 0));
    vecs.push_back(wr(13, 16'hDEAD, 2'b11, 1));
    vecs.push_back(rd(12, 16'h0000, 0, 1));
    vecs.push_back(rd(13, 16'h0000, 0, 1));
    vecs.push_back(rd(5, 16'h0000, 1, 0));
    vecs.push_back(wr(7, 16'h1111, 2'b11, 0));
    vecs.push_back(mk(1, 7, 16'hBEEF, 2'b01, 1, 7, 16'h1111, 0, 0, 1, 16'h11EF, 0, 0, 1, 0));
    vecs.push_back(rd(7, 16'h11EF, 0, 0));
    vecs.push_back(mk(1, 12, 16'h1234, 2'b11, 1, 12, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 0, 1));
    vecs.push_back(mk(1, 2, 16'hABCD, 2'b00, 1, 2, 16'h0000, 1, 0, 1, 16'h0000, 0, 0, 1, 0));
    vecs.push_back(rd(2, 16'h0000, 0, 0));
    vecs.push_back(wr(2, 16'hFFFF, 2'b00, 0));
    vecs.push_back(rd(2, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 15, 16'h5555, 2'b11, 1, 3, 16'h12C3, 0, 0, 0, 16'h12C3, 0, 0, 0, 1));
    vecs.push_back(rd(0, 16'h0000, 1, 0));
    vecs.push_back(rd(1, 16'h0000, 1, 0));
    vecs.push_back(rd(2, 16'h0000, 0, 0));
    vecs.push_back(rd(3, 16'h12C3, 0, 0));
    vecs.push_back(rd(4, 16'h00FF, 0, 0));
    vecs.push_back(rd(5, 16'h0000, 1, 0));
    vecs.push_back(rd(6, 16'h0000, 1, 0));
    vecs.push_back(rd(7, 16'h11EF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset A outputs", {a_data, 10'h0, a_valid, a_uninit, a_err, a_werr, a_coll, 1'b0}, 32'h0);
    chk("reset B outputs", {b_data, 10'h0, b_valid, b_uninit, b_err, b_werr, b_coll, 1'b0}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Table-driven phase; wr_err is checked one cycle behind its vector
    prev_werr = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("A wr_err after vec %0d", i), 32'(a_werr), 32'(prev_werr));
      chk($sformatf("B wr_err after vec %0d", i), 32'(b_werr), 32'(prev_werr));
      prev_werr = vecs[i].werr;
    end
    drain("table");

    // Reset with two reads in flight
    @(posedge clk); #1 rd_enb = 1'b1; rd_addr = 4'd3;
    @(posedge clk); #1 rd_addr = 4'd4;
    @(posedge clk); #1 rd_enb = 1'b0;
    chk("A valid before reset", 32'(a_valid), 32'h1);
    chk("A data before reset", 32'(a_data), 32'h12C3);
    #1 rst = 1'b1;
    #1;
    chk("A outputs on async reset", {a_data, 10'h0, a_valid, a_uninit, a_err, a_werr, a_coll, 1'b0}, 32'h0);
    chk("B outputs on async reset", {b_data, 10'h0, b_valid, b_uninit, b_err, b_werr, b_coll, 1'b0}, 32'h0);
    q_a.delete();
    q_b.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd_enb = 1'b1;
    rd_addr = 4'd3;
    e.data = 16'h0000; e.uninit = 1'b1; e.err = 1'b0; e.coll = 1'b0;
    e.cyc = cyc + 2; q_a.push_back(e);
    e.cyc = cyc + 4; q_b.push_back(e);
    @(posedge clk); #1 rd_enb = 1'b0;
    drain("post-reset");
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
